// File: rtl/gf_mul_if.sv
// Operand/result bundle for gf_mul: start + two operands in, product + done out.
// Handshake: start marks in_1/in_2 valid for one cycle; done marks out valid L cycles later; there is no ready (no back-pressure).
interface gf_mul_if #(
  parameter int M = 8
);
  logic         start;
  logic [M-1:0] in_1;
  logic [M-1:0] in_2;
  logic [M-1:0] out;
  logic         done;

  modport master (output start, output in_1, output in_2, input out, input done);
  modport slave  (input start, input in_1, input in_2, output out, output done);
endinterface

// File: rtl/gf_mul.sv
// GF(2^M) multiplier with optional input/output registers; latency REG_IN+REG_OUT.
// Define GF_MUL_CHECK_EN to compile in a simulation-only reference checker.
module gf_mul #(
  parameter int         M       = 8,
  parameter logic [M:0] POLY    = 9'h11D,
  parameter int         REG_IN  = 1,
  parameter int         REG_OUT = 1
) (
  input  logic      clk,
  input  logic      rst,
  gf_mul_if.slave   bus
);
  localparam int L = REG_IN + REG_OUT;

  // Carry-less multiply, then fold the high bits down from 2M-2 to M.
  function automatic logic [M-1:0] gf_prod(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    logic [2*M-2:0] a_ext;
    logic [2*M-2:0] poly_ext;
    p        = '0;
    a_ext    = (2*M-1)'(a);
    poly_ext = (2*M-1)'(POLY);
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ (a_ext << i);
    end
    for (int k = 2*M-2; k >= M; k--) begin
      if (p[k]) p = p ^ (poly_ext << (k - M));
    end
    return p[M-1:0];
  endfunction

  logic [M-1:0] a_s;
  logic [M-1:0] b_s;
  logic [M-1:0] prod_c;

  generate
    if (REG_IN != 0) begin : g_reg_in
      logic [M-1:0] a_q, a_d, b_q, b_d;
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (bus.start) begin
          a_d = bus.in_1;
          b_d = bus.in_2;
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
      assign a_s = a_q;
      assign b_s = b_q;
    end else begin : g_no_reg_in
      assign a_s = bus.in_1;
      assign b_s = bus.in_2;
    end
  endgenerate

  assign prod_c = gf_prod(a_s, b_s);

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [M-1:0] out_q, out_d;
      always_comb begin
        out_d = prod_c;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
      end
      assign bus.out = out_q;
    end else begin : g_no_reg_out
      assign bus.out = prod_c;
    end
  endgenerate

  generate
    if (L > 0) begin : g_done_sr
      logic [L-1:0] dsr_q, dsr_d;
      always_comb begin
        dsr_d    = dsr_q << 1;
        dsr_d[0] = bus.start;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dsr_q <= '0;
        else     dsr_q <= dsr_d;
      end
      assign bus.done = dsr_q[L-1];
    end else begin : g_done_comb
      assign bus.done = bus.start;
    end
  endgenerate

`ifdef GF_MUL_CHECK_EN
  // Reference uses iterated multiply-by-x so it shares no structure with gf_prod.
  function automatic logic [M-1:0] chk_ref(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ x;
      x = x[M-1] ? ((x << 1) ^ POLY[M-1:0]) : (x << 1);
    end
    return r;
  endfunction

  generate
    if (L == 0) begin : g_chk_comb
      always @(posedge clk) begin
        if (bus.start && (bus.out !== chk_ref(bus.in_1, bus.in_2)))
          $error("gf_mul check: out=%h ref=%h", bus.out, chk_ref(bus.in_1, bus.in_2));
      end
    end else begin : g_chk_pipe
      logic [M-1:0] chk_pipe [L];
      always @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < L; i++) chk_pipe[i] <= '0;
        end else begin
          if (bus.done && (bus.out !== chk_pipe[L-1]))
            $error("gf_mul check: out=%h ref=%h", bus.out, chk_pipe[L-1]);
          for (int i = L-1; i > 0; i--) chk_pipe[i] <= chk_pipe[i-1];
          chk_pipe[0] <= chk_ref(bus.in_1, bus.in_2);
        end
      end
    end
  endgenerate
`endif
endmodule

// File: tb/tb_gf_mul.sv
// Directed bench for gf_mul: all four REG_IN/REG_OUT variants share one stimulus stream.
module tb_gf_mul;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_1 = '0;
  logic [7:0] in_2 = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic       hist_s [2048];
  logic [7:0] hist_a [2048];
  logic [7:0] hist_b [2048];

  always #5 clk = ~clk;

  gf_mul_if #(.M(8)) if0 ();
  gf_mul_if #(.M(8)) if1 ();
  gf_mul_if #(.M(8)) if2 ();
  gf_mul_if #(.M(8)) if3 ();

  assign if0.start = start; assign if0.in_1 = in_1; assign if0.in_2 = in_2;
  assign if1.start = start; assign if1.in_1 = in_1; assign if1.in_2 = in_2;
  assign if2.start = start; assign if2.in_1 = in_1; assign if2.in_2 = in_2;
  assign if3.start = start; assign if3.in_1 = in_1; assign if3.in_2 = in_2;

  gf_mul #(.M(8), .POLY(9'h11D), .REG_IN(0), .REG_OUT(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gf_mul #(.M(8), .POLY(9'h11D), .REG_IN(1), .REG_OUT(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  gf_mul #(.M(8), .POLY(9'h11D), .REG_IN(0), .REG_OUT(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  gf_mul #(.M(8), .POLY(9'h11D), .REG_IN(1), .REG_OUT(1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } vec_t;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // After edge cyc, a latency-lat variant shows the operands present before edge cyc-lat+1.
  task automatic check_reg(input string nm, input int lat, input logic [7:0] o, input logic d);
    int  idx;
    logic es;
    idx = cyc - lat + 1;
    es  = (idx >= 0) ? hist_s[idx] : 1'b0;
    cmp1({nm, ".done"}, d, es);
    if (es) cmp8({nm, ".out"}, o, model(hist_a[idx], hist_b[idx]));
  endtask

  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    cyc++;
    check_reg("u1", 1, if1.out, if1.done);
    check_reg("u2", 1, if2.out, if2.done);
    check_reg("u3", 2, if3.out, if3.done);
    start = s;
    in_1  = a;
    in_2  = b;
    hist_s[cyc+1] = s;
    hist_a[cyc+1] = a;
    hist_b[cyc+1] = b;
    #1;
    cmp8("u0.out", if0.out, model(a, b));
    cmp1("u0.done", if0.done, s);
  endtask

  task automatic check_reset_outputs();
    cmp8("rst.u1.out", if1.out, 8'h00); cmp1("rst.u1.done", if1.done, 1'b0);
    cmp8("rst.u2.out", if2.out, 8'h00); cmp1("rst.u2.done", if2.done, 1'b0);
    cmp8("rst.u3.out", if3.out, 8'h00); cmp1("rst.u3.done", if3.done, 1'b0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    cyc++;
    check_reset_outputs();
    rst = 1'b0;
    for (int k = 0; k < 2048; k++) hist_s[k] = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{8'h02, 8'h8E, 8'h01};
    vecs[1] = '{8'h03, 8'hF4, 8'h01};
    vecs[2] = '{8'h04, 8'h47, 8'h01};
    vecs[3] = '{8'h80, 8'h02, 8'h1D};
    vecs[4] = '{8'hFF, 8'h01, 8'hFF};
    vecs[5] = '{8'h00, 8'hA5, 8'h00};
    vecs[6] = '{8'h80, 8'h80, 8'h13};
    vecs[7] = '{8'h1D, 8'h02, 8'h3A};
    vecs[8] = '{8'h02, 8'h02, 8'h04};
    vecs[9] = '{8'h01, 8'h00, 8'h00};
    for (int k = 0; k < 2048; k++) begin
      hist_s[k] = 1'b0; hist_a[k] = '0; hist_b[k] = '0;
    end

    #1;
    check_reset_outputs();

    // Combinational variant: table vectors plus swapped operands, while rst holds the others.
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; in_1 = vecs[i].a; in_2 = vecs[i].b;
      #1;
      cmp8("l0.tbl", if0.out, vecs[i].p);
      cmp1("l0.done", if0.done, 1'b1);
      in_1 = vecs[i].b; in_2 = vecs[i].a;
      #1;
      cmp8("l0.swap", if0.out, vecs[i].p);
    end
    start = 1'b0;
    cmp1("l0.done0", if0.done, 1'b0);

    do_reset();

    // Single pulse: done exactly one cycle, L cycles later.
    step(1'b1, 8'h80, 8'h02);
    step(1'b0, 8'h55, 8'hAA);
    step(1'b0, 8'h55, 8'hAA);
    step(1'b0, 8'h55, 8'hAA);
    // Held operands after start drops keep the same product on the registered-input variants.
    cmp8("hold.u3.out", if3.out, 8'h1D);
    cmp8("hold.u1.out", if1.out, 8'h1D);
    cmp1("hold.u3.done", if3.done, 1'b0);

    // Continuous start sweep.
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 8'h02);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);

    // Reset one cycle after start: the in-flight product must never show done.
    step(1'b1, 8'h80, 8'h02);
    step(1'b0, 8'h00, 8'h00);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h80, 8'h80);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);

    // Back-to-back mixed pulses.
    for (int i = 0; i < 10; i++) step(i[0], vecs[i].a, vecs[i].b);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
